// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the memory port arbiter.
package mem_port_arbiter_pkg;

  // Grant FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } arb_state_e;

  // Which port owns the transaction currently in flight
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // Default WAIT-state budget before the watchdog gives up on the memory
  localparam int unsigned DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/arb_watchdog.sv
// Clear/enable cycle counter with a terminal-count flag. o_tc is high in the
// enabled cycle whose increment would bring the count to TIMEOUT.
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles; clear has priority so a finished wait restarts at 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = i_en & (r_count == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory between the fetch (I) and data (D) ports.
// Handshake: a port's request is a level held until its done pulse; done is
// a one-cycle registered strobe and the port is masked from arbitration in
// that cycle. Toward memory, m_req is a one-cycle command strobe issued only
// when m_busy is low, and m_done is a one-cycle completion strobe in WAIT.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  output logic          i_stall,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          m_req,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_busy,
  input  logic          m_done,
  input  logic [DW-1:0] m_rdata,
  output logic          err,
  output arb_state_e    dbg_state
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  arb_owner_e r_owner;
  logic       r_prio_i;
  logic       r_is_wr;
  logic       r_err;
  logic       r_i_done;
  logic       r_d_done;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_m_req;
  logic          r_m_wr;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;

  logic w_i_pend;
  logic w_d_pend;
  logic w_grant_i;
  logic w_grant_d;
  logic w_finish;
  logic w_timeout;
  logic w_tc;

  // A port that is completing this cycle is not pending, preventing a re-grant
  assign w_i_pend = i_req & ~r_i_done;
  assign w_d_pend = (d_rd | d_wr) & ~r_d_done;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .i_clr((r_state != ST_WAIT) | w_finish),
    .i_en (r_state == ST_WAIT),
    .o_tc (w_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant/finish decisions; fetch wins a tie only when prio_i is set
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!m_busy) begin
          if (w_i_pend && (!w_d_pend || r_prio_i)) begin
            w_grant_i   = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else if (w_d_pend) begin
            w_grant_d   = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_done || w_tc) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A real response beats the watchdog when both land in the same cycle
  assign w_timeout = w_finish & ~m_done;

  // Grant bookkeeping: owner, write flag and the fairness bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner  <= OWN_D;
      r_prio_i <= 1'b0;
      r_is_wr  <= 1'b0;
    end else if (w_grant_i) begin
      r_owner  <= OWN_I;
      r_prio_i <= 1'b0;
      r_is_wr  <= 1'b0;
    end else if (w_grant_d) begin
      r_owner  <= OWN_D;
      r_is_wr  <= d_wr;
      if (w_i_pend) begin
        r_prio_i <= 1'b1;
      end
    end
  end

  // Memory command registers: loaded on grant, visible only during ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_req   <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else if (w_grant_i) begin
      r_m_req   <= 1'b1;
      r_m_wr    <= 1'b0;
      r_m_addr  <= i_addr;
      r_m_wdata <= '0;
    end else if (w_grant_d) begin
      r_m_req   <= 1'b1;
      r_m_wr    <= d_wr;
      r_m_addr  <= d_addr;
      r_m_wdata <= d_wdata;
    end else begin
      r_m_req   <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end
  end

  // Completion: route read data to the owner and pulse its done for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      if (w_finish) begin
        if (r_owner == OWN_I) begin
          r_i_done  <= 1'b1;
          r_i_rdata <= w_timeout ? '0 : m_rdata;
        end else begin
          r_d_done <= 1'b1;
          if (w_timeout) begin
            r_d_rdata <= '0;
          end else if (!r_is_wr) begin
            r_d_rdata <= m_rdata;
          end
        end
      end
    end
  end

  // Sticky watchdog flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign i_rdata   = r_i_rdata;
  assign i_done    = r_i_done;
  assign i_stall   = i_req & ~r_i_done;
  assign d_rdata   = r_d_rdata;
  assign d_done    = r_d_done;
  assign d_stall   = (d_rd | d_wr) & ~r_d_done;
  assign m_req     = r_m_req;
  assign m_wr      = r_m_wr;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single multi-cycle main memory between the instruction-fetch port (IF stage) and the data port (MEM stage).
- Serialises requests with a grant FSM and routes read data back to the owning port.
- Produces the per-port done/stall signals that the hazard unit uses to freeze the pipeline.
- Includes fetch anti-starvation and a watchdog so a lost memory response cannot hang the core.

Parameters:
- AW, 16, address width
- DW, 16, data width
- TIMEOUT, 32, WAIT-state cycles before the watchdog fires (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- i_req  in  1  fetch read request; level, held until i_done
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch read data; valid while i_done=1
- i_done  out  1  one-cycle completion pulse
- i_stall  out  1  i_req & ~i_done
- d_rd  in  1  data read request; level
- d_wr  in  1  data write request; level
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid while d_done=1
- d_done  out  1  one-cycle completion pulse
- d_stall  out  1  (d_rd|d_wr) & ~d_done
- m_req  out  1  one-cycle memory command strobe
- m_wr  out  1  1 = write command
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_busy  in  1  memory cannot accept a command
- m_done  in  1  memory completion strobe
- m_rdata  in  DW  memory read data; valid with m_done
- err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM=IDLE.
  - All outputs 0, including i_rdata, d_rdata, m_addr and m_wdata.
  - Internal prio_i=0, owner=D, timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT. m_req/m_wr/m_addr/m_wdata are registered and driven only in ISSUE.
- IDLE:
  - A port is pending if its request is high and its done is low. A port whose done is high is masked for that cycle, so no double grant.
  - If m_busy=1 or nothing is pending, stay in IDLE.
  - Only D pending: grant D. Only I pending: grant I.
  - Both pending: grant I if prio_i=1, otherwise grant D.
  - On any grant, latch owner, address, write flag (D only) and wdata, then go to ISSUE.
- prio_i:
  - Set when D is granted while I is pending.
  - Cleared when I is granted.
  - Result: D wins once, then I, alternating under contention; fetch cannot starve.
- Simultaneous d_rd & d_wr: treated as a write.
- ISSUE: exactly one cycle with m_req=1, then WAIT unconditionally. m_done during ISSUE is ignored (protocol violation).
- WAIT:
  - Counter increments each cycle.
  - On m_done: the owner's rdata register captures m_rdata (writes capture nothing and rdata holds its old value). Next cycle the owner's done=1 for exactly one cycle and FSM=IDLE.
  - If the counter reaches TIMEOUT first: err<=1 (sticky until reset), owner's rdata<=0, owner's done pulses, FSM=IDLE, counter cleared.
- Latency: request seen in IDLE at cycle N, m_req at N+1, m_done at M≥N+2, done at M+1. Minimum 3 cycles.
- Done pulses never overlap; at most one port completes per cycle.
- Requester dropping its request mid-transaction: the transaction still completes; the done pulse is harmless.
- Reset mid-transaction: aborts immediately with no done pulse; any late m_done arriving in IDLE is ignored.
- Stalls are combinational from the inputs and the registered done, so the hazard unit can stall in the same cycle the request rises.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10)
  - owner encoding (OWN_I=1'b0, OWN_D=1'b1)
  - default TIMEOUT
- One sub-module, arb_watchdog: clear/enable counter with terminal-count output, width clog2(TIMEOUT+1).

Test Plan:
1. Lone fetch: i_req=1, i_addr=16'h0040, memory returns m_rdata=16'hA5A5 two cycles after m_req -> exactly one m_req with m_addr=16'h0040, m_wr=0; i_done for one cycle with i_rdata=16'hA5A5; i_stall high until then; latency 4 cycles.
2. Store: d_wr=1, d_addr=16'h1000, d_wdata=16'h1234 -> m_req with m_wr=1 carrying that addr/data; d_done pulses once; d_rdata unchanged.
3. Contention: i_req and d_rd held continuously with immediate re-requests -> grant order D, I, D, I; never two consecutive D grants while I is pending.
4. m_busy held for 5 cycles with d_rd pending -> no m_req while busy; m_req in the cycle after m_busy falls.
5. Watchdog: TIMEOUT=4, m_done never asserted -> owner done pulses 4 cycles into WAIT with rdata=0; err=1 and stays 1 through later normal transactions.
6. Async reset asserted in WAIT -> all outputs 0 immediately; an m_done arriving after reset release produces no done pulse.
